// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: FSM states, fault codes and the
// default reset PC (also used by the next-PC logic on the other side).
package pc_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int          TIMEOUT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  // Instruction addresses must be word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_timeout_ctr.sv
// Wait-cycle counter for an outstanding fetch. Cleared when the request is
// granted, advanced every WAIT cycle, and flags expiry on its last allowed
// cycle (count == TIMEOUT-1).
module pc_fetch_unit_timeout_ctr
  import pc_fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter holder and instruction fetcher. Fetches the word at pc,
// presents it to decode until it retires, then loads the next PC.
//
// Handshakes:
//   imem_req/imem_gnt : request is offered while imem_req=1 (REQ state) and is
//                       accepted on the cycle imem_gnt=1; gnt is ignored when
//                       no request is offered.
//   imem_rvalid       : data is taken on the cycle rvalid=1 in WAIT only.
//   inst_valid/ready  : inst_out/pc_out are stable while inst_valid=1; the
//                       instruction retires on the cycle inst_valid=1 and
//                       inst_ready=1, which is the only cycle npc_in is used.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  input  logic [31:0] npc_in,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retire_cnt,
  output state_e      dbg_state_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic        ctr_clr;
  logic        ctr_en;
  logic        ctr_expired;

  pc_fetch_unit_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (ctr_clr),
    .en_i      (ctr_en),
    .expired_o (ctr_expired)
  );

  // Next-state and datapath updates; every target defaults to holding.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    retire_cnt_d = retire_cnt_q;
    fault_code_d = fault_code_q;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt) begin
          ctr_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ctr_en = 1'b1;
        // Data arriving on the last allowed cycle still counts.
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = ST_HOLD;
        end else if (ctr_expired) begin
          fault_code_d = FAULT_TIMEOUT;
          state_d      = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          // The instruction retires even when its successor is misaligned.
          retire_cnt_d = retire_cnt_q + 32'd1;
          if (is_aligned(npc_in)) begin
            pc_d    = npc_in;
            state_d = ST_REQ;
          end else begin
            fault_code_d = FAULT_MISALIGN;
            state_d      = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      retire_cnt_q <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      retire_cnt_q <= retire_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == ST_HOLD);
  assign inst_out    = inst_q;
  assign pc_out      = pc_q;
  assign fault       = (state_q == ST_FAULT);
  assign fault_code  = fault_code_q;
  assign retire_cnt  = retire_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a small memory driver serves fetches,
// pushes the expected {pc, instruction} pair when it returns data, and the
// scoreboard pops and compares it when the DUT presents the instruction.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          TMO    = 16;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] npc_in;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retire_cnt;
  state_e      dbg_state;

  // Scoreboard and reference model
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_inst;
  int          checks;
  int          errors;

  pc_fetch_unit #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .npc_in      (npc_in),
    .fault       (fault),
    .fault_code  (fault_code),
    .retire_cnt  (retire_cnt),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reset for two cycles, check reset values, release at a negedge so the
  // following cycle is cycle 0 (IDLE).
  task automatic do_reset();
    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req",    imem_req,   0);
    check("rst_valid",  inst_valid, 0);
    check("rst_inst",   inst_out,   0);
    check("rst_fault",  fault,      0);
    check("rst_code",   fault_code, FAULT_NONE);
    check("rst_cnt",    retire_cnt, 0);
    check("rst_addr",   imem_addr,  RST_PC);
    m_pc   = RST_PC;
    m_cnt  = 32'd0;
    m_inst = 32'd0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  // Serve one fetch: wait for req, grant after gnt_dly cycles, return data
  // rv_dly cycles after the grant, then score the presented instruction.
  task automatic serve_fetch(input int gnt_dly, input int rv_dly,
                             input logic [31:0] data, output int req_wait);
    logic [63:0] e;
    int n;
    int req_cycles;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_wait = n;
    check("req_seen", imem_req, 1);
    check("imem_addr", imem_addr, m_pc);
    req_cycles = 0;
    for (int i = 0; i <= gnt_dly; i++) begin
      if (imem_req) req_cycles++;
      imem_gnt = (i == gnt_dly);
      @(negedge clk);
    end
    imem_gnt = 1'b0;
    check("req_cycles", req_cycles, gnt_dly + 1);
    check("req_drop", imem_req, 0);
    for (int i = 0; i < rv_dly; i++) begin
      if (inst_valid || fault) check("wait_quiet", {inst_valid, fault}, 2'b00);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_q.push_back({m_pc, data});
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    check("inst_valid", inst_valid, 1);
    check("no_fault", fault, 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pc",   pc_out,   e[63:32]);
      check("sb_inst", inst_out, e[31:0]);
    end else begin
      check("sb_empty", 0, 1);
    end
    m_inst = data;
  endtask

  // Retire the held instruction with the given next PC.
  task automatic retire(input logic [31:0] npc);
    inst_ready = 1'b1;
    npc_in     = npc;
    @(negedge clk);
    inst_ready = 1'b0;
    npc_in     = $urandom();
    m_cnt      = m_cnt + 32'd1;
    if (npc[1:0] == 2'b00) m_pc = npc;
  endtask

  initial begin
    int w;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    imem_rdata = 32'd0;
    npc_in     = 32'd0;
    @(negedge clk);
    do_reset();

    // Minimum latency fetch
    serve_fetch(0, 0, 32'h2008_0005, w);
    check("req_latency", w, 1);

    // Hold: ready low, npc_in wiggling has no effect
    for (int i = 0; i < 3; i++) begin
      npc_in = $urandom() | 32'h1;
      @(negedge clk);
      check("hold_valid", inst_valid, 1);
      check("hold_inst",  inst_out,   32'h2008_0005);
      check("hold_pc",    pc_out,     RST_PC);
    end

    // Two retires with aligned next PCs
    retire(32'h0000_3004);
    serve_fetch(0, 0, $urandom(), w);
    check("retire_to_req", w, 0);
    retire(32'h0000_3040);
    check("retire_cnt2", retire_cnt, m_cnt);
    serve_fetch(0, 0, $urandom(), w);

    // Delayed grant and data
    retire(32'h0000_3080);
    serve_fetch(5, 3, 32'hCAFE_0001, w);

    // A few random-latency fetches
    for (int k = 0; k < 4; k++) begin
      retire(m_pc + 32'd4 * 32'($urandom_range(1, 8)));
      serve_fetch($urandom_range(0, 4), $urandom_range(0, TMO - 1), $urandom(), w);
    end
    check("retire_cnt_run", retire_cnt, m_cnt);

    // Timeout: grant, then no rvalid
    retire(m_pc + 32'd4);
    while (!imem_req) @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (fault) check("early_timeout", fault, 0);
      @(negedge clk);
    end
    check("tmo_fault", fault,      1);
    check("tmo_code",  fault_code, FAULT_TIMEOUT);
    check("tmo_state", dbg_state,  ST_FAULT);
    imem_rvalid = 1'b1;
    imem_gnt    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (imem_req || inst_valid) check("fault_quiet", {imem_req, inst_valid}, 2'b00);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    check("fault_sticky", fault,      1);
    check("fault_inst",   inst_out,   m_inst);
    check("fault_cnt",    retire_cnt, m_cnt);
    check("fault_pc",     imem_addr,  m_pc);

    // Misaligned next PC
    do_reset();
    serve_fetch(0, 1, 32'h1234_5678, w);
    retire(32'h0000_3006);
    check("mis_fault", fault,      1);
    check("mis_code",  fault_code, FAULT_MISALIGN);
    check("mis_pc",    pc_out,     RST_PC);
    check("mis_cnt",   retire_cnt, 32'd1);
    check("mis_valid", inst_valid, 0);

    // Reset while waiting for data; late rvalid is dropped
    do_reset();
    retire_dummy_fetch();
    check("abort_valid", inst_valid, 0);
    check("abort_inst",  inst_out,   0);
    check("abort_req",   imem_req,   1);
    check("abort_addr",  imem_addr,  RST_PC);
    serve_fetch(0, 2, 32'h0BAD_F00D, w);

    // Final report
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Get into WAIT, reset for one cycle, then present a stale rvalid in IDLE.
  task automatic retire_dummy_fetch();
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0000;
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential producer of the program counter; it is the other end of the next-PC interface.
- Holds the architectural PC and fetches the instruction at PC from instruction memory over a req/gnt/rvalid handshake.
- Presents the instruction and its PC to decode and the next-PC logic.
- Loads the returned next PC when the instruction retires.
- Detects misaligned next-PC values and memory timeouts.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TIMEOUT, 16, max cycles spent in WAIT for rvalid before fault (1..65535).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, asserted in REQ only
- imem_addr  out  32  fetch address, equals pc
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  instruction data valid this cycle
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst_out/pc_out valid (HOLD state)
- inst_ready  in  1  downstream retires instruction this cycle
- inst_out  out  32  captured instruction
- pc_out  out  32  PC of inst_out
- npc_in  in  32  next PC computed for the current instruction
- fault  out  1  sticky fault flag
- fault_code  out  2  01 misaligned npc, 10 fetch timeout, 00 none
- retire_cnt  out  32  count of retired instructions

Behaviour:
- Reset is synchronous, active-high, one clock, and wins over every other event. On reset:
  - pc=RESET_PC
  - state=IDLE
  - imem_req=0, inst_valid=0, inst_out=0
  - fault=0, fault_code=00
  - retire_cnt=0, timeout counter=0
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: outputs idle; unconditionally go to REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. If imem_gnt, go to WAIT and clear the timeout counter; otherwise stay in REQ (no timeout while ungranted).
- WAIT: imem_req=0; counter increments each cycle.
  - imem_rvalid: capture imem_rdata into inst_out, go to HOLD.
  - Counter reaches TIMEOUT-1 without rvalid: go to FAULT, fault_code=10.
  - rvalid wins if both happen in the same cycle.
- HOLD: inst_valid=1, pc_out=pc. Retire occurs when inst_ready=1 in HOLD.
  - Retire with npc_in[1:0]==00: pc<=npc_in, retire_cnt+=1 (wraps 2^32-1 to 0), inst_valid<=0, go to REQ.
  - Retire with npc_in[1:0]!=00: go to FAULT, fault_code=01; pc is unchanged; retire_cnt+=1 (the instruction did retire).
  - inst_ready=0: hold all outputs stable.
- FAULT: fault=1; imem_req=0, inst_valid=0. pc, inst_out and retire_cnt are frozen. Leave only by rst.
- imem_rvalid and imem_gnt are ignored outside WAIT and REQ respectively. A late rvalid after reset, or while in REQ, is discarded.
- Reset mid-fetch (REQ/WAIT/HOLD) aborts the transaction; fetch restarts from RESET_PC.
- npc_in is sampled only on the retire cycle; its value at other times has no effect.
- pc wraps naturally; no range check other than alignment.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the first WAIT cycle:
  - cycle 0 after reset release is IDLE;
  - cycle 1 REQ;
  - cycle 2 WAIT;
  - cycle 3 HOLD, inst_valid=1.
- Steady-state throughput is one instruction per 3 cycles.

Decomposition:
- Shared package:
  - state enum (IDLE, REQ, WAIT, HOLD, FAULT);
  - fault code constants FAULT_NONE/FAULT_MISALIGN/FAULT_TIMEOUT;
  - default RESET_PC constant, shared with NPC defines.
- Sub-module: fetch_timeout_ctr (clear, enable, expire at TIMEOUT-1). Everything else stays in one module.

Test Plan:
- Reset release, gnt and rvalid immediate, imem_rdata=32'h2008_0005 -> imem_addr=32'h0000_3000 in cycle 1; inst_valid=1 in cycle 3 with inst_out=32'h2008_0005, pc_out=32'h0000_3000.
- Retire with npc_in=32'h0000_3004, then again with npc_in=32'h0000_3040 -> next imem_addr values 32'h0000_3004 and 32'h0000_3040; retire_cnt=2.
- gnt delayed 5 cycles, rvalid delayed 3 cycles after gnt -> imem_req held 6 cycles; no fault; inst_valid asserts the cycle after rvalid.
- No rvalid for TIMEOUT=16 cycles after gnt -> fault=1, fault_code=10; imem_req stays 0 until rst.
- Retire with npc_in=32'h0000_3006 -> fault_code=01; pc_out frozen at prior PC; retire_cnt incremented once.
- Assert rst while in WAIT, then rvalid the next cycle -> rvalid ignored; a fresh fetch at 32'h0000_3000; inst_valid=0 until the new rvalid.
